// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: decodes control-flow requests into the PC select, owns the
// return-address stack, and generates fetch flush and halt.
module pc_seq_ctrl #(
  parameter int unsigned AW        = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  input  logic          stall_in,
  input  logic          jump_in,
  input  logic          call_in,
  input  logic          ret_in,
  input  logic          halt_in,
  output logic [1:0]    ps_out,
  output logic [AW-1:0] ra_out,
  output logic          flush_out,
  output logic          halted_out,
  output logic          ras_err_out
);

  localparam int unsigned IdxW = $clog2(RAS_DEPTH);
  localparam int unsigned SpW  = IdxW + 1;
  localparam logic [SpW-1:0] SpFull = SpW'(RAS_DEPTH);

  localparam logic [1:0] PsHold = 2'b00;
  localparam logic [1:0] PsSeq  = 2'b01;
  localparam logic [1:0] PsIa   = 2'b10;
  localparam logic [1:0] PsRa   = 2'b11;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFlush,
    StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [SpW-1:0]  sp_q, sp_d;
  logic            err_q, err_d;
  logic [AW-1:0]   ras_q [RAS_DEPTH];

  logic            push;
  logic            pop;
  logic            err_set;
  logic [AW-1:0]   ret_addr;
  logic [IdxW-1:0] top_idx;
  logic            ras_empty;
  logic            ras_full;

  assign ret_addr  = pc_in + AW'(1);
  assign ras_empty = (sp_q == '0);
  assign ras_full  = (sp_q == SpFull);
  // Low bits wrap correctly for sp == RAS_DEPTH since the top bit alone is set then.
  assign top_idx   = sp_q[IdxW-1:0] - IdxW'(1);

  always_comb begin
    state_d   = state_q;
    ps_out    = PsHold;
    flush_out = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (halt_in) begin
          state_d = StHalt;
        end else if (stall_in) begin
          ps_out = PsHold;
        end else if (ret_in) begin
          if (!ras_empty) begin
            ps_out  = PsRa;
            pop     = 1'b1;
            state_d = StFlush;
          end else begin
            ps_out  = PsSeq;
            err_set = 1'b1;
          end
        end else if (call_in) begin
          ps_out  = PsIa;
          state_d = StFlush;
          if (ras_full) begin
            err_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end else if (jump_in) begin
          ps_out  = PsIa;
          state_d = StFlush;
        end else begin
          ps_out = PsSeq;
        end
      end
      StFlush: begin
        // Requests seen here belong to the squashed fetch slot.
        flush_out = 1'b1;
        if (stall_in) begin
          ps_out = PsHold;
        end else begin
          ps_out  = PsSeq;
          state_d = StRun;
        end
      end
      StHalt: begin
        ps_out = PsHold;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_comb begin
    sp_d = sp_q;
    if (push) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop) begin
      sp_d = sp_q - SpW'(1);
    end
    err_d = err_q | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else if (push) begin
      ras_q[sp_q[IdxW-1:0]] <= ret_addr;
    end
  end

  assign ra_out      = ras_empty ? '0 : ras_q[top_idx];
  assign halted_out  = (state_q == StHalt);
  assign ras_err_out = err_q;

endmodule
